k005297_pgverify: RTL and testbench
===================================

// Module: k005297_pgverify
// PURPOSE
//  Page-verify sequencer directly downstream of the serial checksum comparator.
//  Per page: samples the checksum-equal flag at page end, captures the 12-bit invalid-page
//  marker shifted out LSB-first, judges the page and drives retry/accept/fail to the
//  page-transfer controller. Bounded retry counter; raises fatal error when exhausted.
// PARAMETERS
//  MAX_RETRY     3        retries allowed per page before fatal (1..7)
//  MARK_W        12       invalid-page marker width, bits
//  INVAL_PATTERN 12'hFFF  marker value identifying a bad-page-map entry
// PORTS
//  i_MCLK            in   1       master clock
//  i_MRST            in   1       synchronous reset, active-high
//  i_CLK2M_PCEN_n    in   1       2 MHz clock enable, active-low
//  i_PAGE_START      in   1       page transfer begins (1-CE pulse)
//  i_MARK_SHIFT      in   1       marker bit valid this CE (const-SR shifting)
//  i_INVALPG_LSB     in   1       marker serial bit, LSB first
//  i_PAGE_END        in   1       comparison finished, sumeq final (1-CE pulse)
//  i_SUMEQ_n         in   1       0 = checksum matched
//  i_ABORT           in   1       controller abort; return to IDLE
//  o_PAGE_OK         out  1       1-CE pulse: page accepted
//  o_PAGE_INVAL      out  1       1-CE pulse: page is a bad-map entry, skip
//  o_RETRY_REQ       out  1       1-CE pulse: re-read same page
//  o_ERR_FATAL       out  1       sticky; retries exhausted
//  o_RETRY_CNT       out  3       retries consumed on current page
//  o_BUSY            out  1       1 in ACCUM/JUDGE
// BEHAVIOUR
//  - Only i_MRST acts on every i_MCLK edge; all other state updates only when
//    i_CLK2M_PCEN_n==0 ("CE"). Inputs sampled on CE only.
//  - Reset: state IDLE, all outputs 0, marker reg 0, bit count 0, o_RETRY_CNT 0,
//    o_ERR_FATAL 0. Reset mid-page discards everything.
//  - States: IDLE, ACCUM, JUDGE, FAIL.
//    IDLE : i_PAGE_START -> ACCUM; clear marker reg and bit count. Retry count cleared only
//           if previous page ended OK/INVAL (kept after RETRY_REQ).
//    ACCUM: i_MARK_SHIFT -> mark <= {bit, mark[MARK_W-1:1]}, count++ saturating at MARK_W;
//           i_PAGE_END -> latch i_SUMEQ_n, go JUDGE. Shift and end in same CE: bit taken
//           first, then judged using updated marker.
//    JUDGE (one CE), priority order:
//           count!=MARK_W            -> treat as mismatch (short marker)
//           mark==INVAL_PATTERN      -> o_PAGE_INVAL, retry cnt 0, IDLE (sum ignored)
//           sumeq_n==0               -> o_PAGE_OK, retry cnt 0, IDLE
//           mismatch, cnt<MAX_RETRY  -> o_RETRY_REQ, cnt++, IDLE
//           mismatch, cnt==MAX_RETRY -> o_ERR_FATAL<=1, FAIL
//    FAIL : ignores all inputs except i_MRST; o_ERR_FATAL held 1.
//  - i_ABORT in ACCUM/JUDGE: -> IDLE next CE, no pulse, retry cnt 0; lower priority than
//    i_MRST, higher than all other events. i_PAGE_START outside IDLE is ignored.
//  - Pulse outputs are registered: asserted the CE after JUDGE decision, held exactly one
//    CE period (deassert on next CE). Latency PAGE_END -> pulse = 2 CE.
//  - o_BUSY registered from state; o_RETRY_CNT width 3, never exceeds MAX_RETRY.
// TESTING
//  - START, 12 shifts of 12'h000, END with SUMEQ_n=0 -> o_PAGE_OK 2 CE after END, cnt 0.
//  - 12 shifts of 12'hFFF, SUMEQ_n=1 -> o_PAGE_INVAL pulse, no retry, cnt 0.
//  - 4 passes with SUMEQ_n=1 -> RETRY_REQ x3 (cnt 1,2,3), 4th -> o_ERR_FATAL=1, FAIL;
//    later START ignored until i_MRST.
//  - Only 11 shifts then END, SUMEQ_n=0 -> RETRY_REQ (short marker), cnt 1.
//  - CE held high for 5 MCLK with PAGE_END asserted -> no state change; abort mid-ACCUM
//    -> IDLE, no pulse; i_MRST mid-ACCUM with CE high -> all outputs 0 next MCLK.

Source files
------------

// File: rtl/k005297_pgverify.sv
// k005297_pgverify
//   Page-verify sequencer that sits behind the serial checksum comparator.
//   For each page it collects the invalid-page marker (shifted in LSB first),
//   latches the checksum-equal flag at page end, and then makes one decision:
//   accept, skip as a bad-map entry, retry, or raise a fatal error.
//
// Ports
//   i_MCLK          master clock
//   i_MRST          synchronous reset, active-high (acts on every i_MCLK edge)
//   i_CLK2M_PCEN_n  clock enable, active-low; all other state moves only on CE
//   i_PAGE_START    page transfer begins (1-CE pulse)
//   i_MARK_SHIFT    marker bit valid this CE
//   i_INVALPG_LSB   marker serial bit, LSB first
//   i_PAGE_END      comparison finished; i_SUMEQ_n is final
//   i_SUMEQ_n       0 = checksum matched
//   i_ABORT         controller abort; drops the page and returns to IDLE
//   o_PAGE_OK       1-CE pulse: page accepted
//   o_PAGE_INVAL    1-CE pulse: page is a bad-map entry
//   o_RETRY_REQ     1-CE pulse: re-read same page
//   o_ERR_FATAL     sticky; retries exhausted
//   o_RETRY_CNT     retries consumed on the current page
//   o_BUSY          high while in ACCUM/JUDGE
module k005297_pgverify #(
  parameter int               MAX_RETRY     = 3,
  parameter int               MARK_W        = 12,
  parameter logic [MARK_W-1:0] INVAL_PATTERN = 12'hFFF
) (
  input  logic       i_MCLK,
  input  logic       i_MRST,
  input  logic       i_CLK2M_PCEN_n,
  input  logic       i_PAGE_START,
  input  logic       i_MARK_SHIFT,
  input  logic       i_INVALPG_LSB,
  input  logic       i_PAGE_END,
  input  logic       i_SUMEQ_n,
  input  logic       i_ABORT,
  output logic       o_PAGE_OK,
  output logic       o_PAGE_INVAL,
  output logic       o_RETRY_REQ,
  output logic       o_ERR_FATAL,
  output logic [2:0] o_RETRY_CNT,
  output logic       o_BUSY
);

  localparam int CW = $clog2(MARK_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_JUDGE, S_FAIL} state_t;

  state_t            r_state, w_nxt;
  logic [MARK_W-1:0] r_mark;
  logic [CW-1:0]     r_bits;
  logic              r_sumeq_n;
  logic [2:0]        r_cnt;
  logic              r_ok, r_inval, r_retry, r_fatal, r_busy;

  logic w_ce;
  logic w_ok, w_inval, w_retry, w_fatal_set;
  logic w_cnt_clr, w_cnt_inc, w_acc_clr, w_accum_live, w_mismatch;

  assign w_ce = ~i_CLK2M_PCEN_n;
  // ACCUM activity is suppressed by abort, which outranks everything but reset.
  assign w_accum_live = (r_state == S_ACCUM) && !i_ABORT;

  always_comb begin
    w_nxt       = r_state;
    w_ok        = 1'b0;
    w_inval     = 1'b0;
    w_retry     = 1'b0;
    w_fatal_set = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_acc_clr   = 1'b0;
    w_mismatch  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_PAGE_START) begin
          w_nxt     = S_ACCUM;
          w_acc_clr = 1'b1;
        end
      end
      S_ACCUM: begin
        if (i_ABORT) begin
          w_nxt     = S_IDLE;
          w_cnt_clr = 1'b1;
        end else if (i_PAGE_END) begin
          w_nxt = S_JUDGE;
        end
      end
      S_JUDGE: begin
        w_nxt = S_IDLE;
        if (i_ABORT) begin
          w_cnt_clr = 1'b1;
        end else if (r_bits != CW'(MARK_W)) begin
          // A short marker cannot be trusted, so the page is re-read.
          w_mismatch = 1'b1;
        end else if (r_mark == INVAL_PATTERN) begin
          w_inval   = 1'b1;
          w_cnt_clr = 1'b1;
        end else if (!r_sumeq_n) begin
          w_ok      = 1'b1;
          w_cnt_clr = 1'b1;
        end else begin
          w_mismatch = 1'b1;
        end
        if (w_mismatch) begin
          if (r_cnt < 3'(MAX_RETRY)) begin
            w_retry   = 1'b1;
            w_cnt_inc = 1'b1;
          end else begin
            w_fatal_set = 1'b1;
            w_nxt       = S_FAIL;
          end
        end
      end
      default: w_nxt = S_FAIL;  // FAIL only leaves via reset
    endcase
  end

  always_ff @(posedge i_MCLK) begin
    if (i_MRST) begin
      r_state   <= S_IDLE;
      r_mark    <= '0;
      r_bits    <= '0;
      r_sumeq_n <= 1'b0;
      r_cnt     <= '0;
      r_ok      <= 1'b0;
      r_inval   <= 1'b0;
      r_retry   <= 1'b0;
      r_fatal   <= 1'b0;
      r_busy    <= 1'b0;
    end else if (w_ce) begin
      r_state <= w_nxt;
      // Pulses are rewritten every CE, so each lasts exactly one CE period.
      r_ok    <= w_ok;
      r_inval <= w_inval;
      r_retry <= w_retry;
      r_fatal <= r_fatal | w_fatal_set;
      r_busy  <= (w_nxt == S_ACCUM) || (w_nxt == S_JUDGE);

      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + 3'd1;

      if (w_acc_clr) begin
        r_mark <= '0;
        r_bits <= '0;
      end else if (w_accum_live && i_MARK_SHIFT) begin
        // Shift happens before the judge CE, so a bit arriving with
        // PAGE_END is already part of the judged marker.
        r_mark <= {i_INVALPG_LSB, r_mark[MARK_W-1:1]};
        if (r_bits != CW'(MARK_W)) r_bits <= r_bits + CW'(1);
      end

      if (w_accum_live && i_PAGE_END) r_sumeq_n <= i_SUMEQ_n;
    end
  end

  assign o_PAGE_OK    = r_ok;
  assign o_PAGE_INVAL = r_inval;
  assign o_RETRY_REQ  = r_retry;
  assign o_ERR_FATAL  = r_fatal;
  assign o_RETRY_CNT  = r_cnt;
  assign o_BUSY       = r_busy;

endmodule

// File: tb/tb_k005297_pgverify.sv
module tb_k005297_pgverify;

  logic       i_MCLK = 1'b0;
  logic       i_MRST = 1'b0;
  logic       i_CLK2M_PCEN_n = 1'b1;
  logic       i_PAGE_START = 1'b0, i_MARK_SHIFT = 1'b0, i_INVALPG_LSB = 1'b0;
  logic       i_PAGE_END = 1'b0, i_SUMEQ_n = 1'b1, i_ABORT = 1'b0;
  logic       o_PAGE_OK, o_PAGE_INVAL, o_RETRY_REQ, o_ERR_FATAL, o_BUSY;
  logic [2:0] o_RETRY_CNT;

  k005297_pgverify dut (
    .i_MCLK(i_MCLK), .i_MRST(i_MRST), .i_CLK2M_PCEN_n(i_CLK2M_PCEN_n),
    .i_PAGE_START(i_PAGE_START), .i_MARK_SHIFT(i_MARK_SHIFT),
    .i_INVALPG_LSB(i_INVALPG_LSB), .i_PAGE_END(i_PAGE_END),
    .i_SUMEQ_n(i_SUMEQ_n), .i_ABORT(i_ABORT),
    .o_PAGE_OK(o_PAGE_OK), .o_PAGE_INVAL(o_PAGE_INVAL),
    .o_RETRY_REQ(o_RETRY_REQ), .o_ERR_FATAL(o_ERR_FATAL),
    .o_RETRY_CNT(o_RETRY_CNT), .o_BUSY(o_BUSY)
  );

  always #5 i_MCLK = ~i_MCLK;

  localparam logic [2:0] K_NONE = 3'b000, K_OK = 3'b100, K_INV = 3'b010, K_RTY = 3'b001;

  typedef struct {
    logic [2:0] kind;
    logic [2:0] cnt;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   ce_cnt = 0;
  logic [2:0] mon_obs;
  exp_t       mon_it;

  // Scoreboard monitor: any pulse seen after a CE edge must match the head
  // expectation, including the CE index at which it was due.
  always @(posedge i_MCLK) begin
    if (!i_MRST && !i_CLK2M_PCEN_n) begin
      ce_cnt++;
      #1;
      mon_obs = {o_PAGE_OK, o_PAGE_INVAL, o_RETRY_REQ};
      if (mon_obs != 3'b000) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pulse got=%b cnt=%0d ce=%0d want=none", mon_obs, o_RETRY_CNT, ce_cnt);
        end else begin
          mon_it = sb.pop_front();
          if (mon_obs !== mon_it.kind || o_RETRY_CNT !== mon_it.cnt || ce_cnt != mon_it.due) begin
            bad++;
            $display("FAIL pulse got kind=%b cnt=%0d ce=%0d want kind=%b cnt=%0d ce=%0d",
                     mon_obs, o_RETRY_CNT, ce_cnt, mon_it.kind, mon_it.cnt, mon_it.due);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // One CE: inputs applied for a single enabled MCLK, then one disabled MCLK.
  task automatic step(input logic st, input logic sh, input logic b,
                      input logic en, input logic sn, input logic ab);
    @(negedge i_MCLK);
    i_PAGE_START = st; i_MARK_SHIFT = sh; i_INVALPG_LSB = b;
    i_PAGE_END = en; i_SUMEQ_n = sn; i_ABORT = ab;
    i_CLK2M_PCEN_n = 1'b0;
    @(posedge i_MCLK); #1;
    i_CLK2M_PCEN_n = 1'b1;
    i_PAGE_START = 0; i_MARK_SHIFT = 0; i_INVALPG_LSB = 0; i_PAGE_END = 0; i_ABORT = 0;
    @(posedge i_MCLK);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 1, 0);
  endtask

  task automatic do_reset();
    @(negedge i_MCLK);
    i_MRST = 1'b1;
    @(posedge i_MCLK); #1;
    i_MRST = 1'b0;
  endtask

  task automatic run_page(input logic [11:0] mark, input int nbits, input logic sn,
                          input logic merge, input logic exp_busy,
                          input logic [2:0] kind, input logic [2:0] cnt);
    step(1, 0, 0, 0, 1, 0);
    total++;
    if (o_BUSY !== exp_busy) begin
      bad++; $display("FAIL busy_after_start got=%b want=%b", o_BUSY, exp_busy);
    end
    for (int i = 0; i < nbits; i++)
      step(0, 1, mark[i], merge && (i == nbits - 1), sn, 0);
    if (!(merge && nbits > 0)) step(0, 0, 0, 1, sn, 0);
    if (kind != K_NONE) sb.push_back('{kind: kind, cnt: cnt, due: ce_cnt + 1});
    idle(3);
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL missing_pulse got=none want kind=%b cnt=%0d", kind, cnt);
      sb.delete();
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({o_PAGE_OK, o_PAGE_INVAL, o_RETRY_REQ, o_ERR_FATAL, o_BUSY, o_RETRY_CNT} !== 8'h00) begin
      bad++; $display("FAIL reset_outputs got=%b want=00000000",
                      {o_PAGE_OK, o_PAGE_INVAL, o_RETRY_REQ, o_ERR_FATAL, o_BUSY, o_RETRY_CNT});
    end
  endtask

  task automatic test_ok();
    run_page(12'h000, 12, 1'b0, 1'b0, 1'b1, K_OK, 3'd0);
    run_page(12'h123, 12, 1'b0, 1'b1, 1'b1, K_OK, 3'd0);  // last shift with END
  endtask

  task automatic test_inval();
    run_page(12'hFFF, 12, 1'b1, 1'b0, 1'b1, K_INV, 3'd0);
    run_page(12'hFFF, 12, 1'b0, 1'b1, 1'b1, K_INV, 3'd0);
  endtask

  task automatic test_short();
    run_page(12'h000, 11, 1'b0, 1'b0, 1'b1, K_RTY, 3'd1);
    run_page(12'h0F0, 12, 1'b0, 1'b0, 1'b1, K_OK, 3'd0);
  endtask

  task automatic test_ce_hold();
    step(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 12; i++) step(0, 1, 1'b0, 0, 1, 0);
    @(negedge i_MCLK);
    i_PAGE_END = 1'b1; i_SUMEQ_n = 1'b1; i_MARK_SHIFT = 1'b1;
    repeat (5) @(posedge i_MCLK);
    #1;
    i_PAGE_END = 1'b0; i_MARK_SHIFT = 1'b0;
    total++;
    if (o_BUSY !== 1'b1 || o_RETRY_CNT !== 3'd0) begin
      bad++; $display("FAIL ce_hold got busy=%b cnt=%0d want busy=1 cnt=0", o_BUSY, o_RETRY_CNT);
    end
    step(0, 0, 0, 1, 0, 0);
    sb.push_back('{kind: K_OK, cnt: 3'd0, due: ce_cnt + 1});
    idle(3);
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL ce_hold_pulse got=none want=ok"); sb.delete();
    end
  endtask

  task automatic test_abort();
    run_page(12'h000, 5, 1'b0, 1'b0, 1'b1, K_RTY, 3'd1);
    step(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 1'b1, 0, 1, 0);
    step(0, 0, 0, 0, 1, 1);
    total++;
    if (o_BUSY !== 1'b0 || o_RETRY_CNT !== 3'd0) begin
      bad++; $display("FAIL abort_accum got busy=%b cnt=%0d want busy=0 cnt=0", o_BUSY, o_RETRY_CNT);
    end
    run_page(12'h000, 3, 1'b0, 1'b0, 1'b1, K_RTY, 3'd1);
    // abort while in JUDGE
    step(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 12; i++) step(0, 1, 1'b0, 0, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 1, 1);
    idle(3);
    total++;
    if (o_BUSY !== 1'b0 || o_RETRY_CNT !== 3'd0 || o_ERR_FATAL !== 1'b0) begin
      bad++; $display("FAIL abort_judge got busy=%b cnt=%0d fatal=%b want 0 0 0",
                      o_BUSY, o_RETRY_CNT, o_ERR_FATAL);
    end
  endtask

  task automatic test_back_to_back();
    run_page(12'h5A5, 12, 1'b1, 1'b0, 1'b1, K_RTY, 3'd1);
    run_page(12'h5A5, 12, 1'b1, 1'b0, 1'b1, K_RTY, 3'd2);
    run_page(12'h5A5, 12, 1'b1, 1'b0, 1'b1, K_RTY, 3'd3);
    run_page(12'h5A5, 12, 1'b1, 1'b0, 1'b1, K_NONE, 3'd0);
    total++;
    if (o_ERR_FATAL !== 1'b1 || o_BUSY !== 1'b0 || o_RETRY_CNT !== 3'd3) begin
      bad++; $display("FAIL fatal got fatal=%b busy=%b cnt=%0d want 1 0 3",
                      o_ERR_FATAL, o_BUSY, o_RETRY_CNT);
    end
    run_page(12'h000, 12, 1'b0, 1'b0, 1'b0, K_NONE, 3'd0);
    total++;
    if (o_ERR_FATAL !== 1'b1 || o_BUSY !== 1'b0) begin
      bad++; $display("FAIL fail_ignores_start got fatal=%b busy=%b want 1 0", o_ERR_FATAL, o_BUSY);
    end
    do_reset();
    total++;
    if (o_ERR_FATAL !== 1'b0 || o_RETRY_CNT !== 3'd0) begin
      bad++; $display("FAIL reset_from_fail got fatal=%b cnt=%0d want 0 0", o_ERR_FATAL, o_RETRY_CNT);
    end
    run_page(12'h000, 12, 1'b0, 1'b0, 1'b1, K_OK, 3'd0);
  endtask

  task automatic test_mrst_mid();
    run_page(12'h000, 2, 1'b0, 1'b0, 1'b1, K_RTY, 3'd1);
    step(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 1'b1, 0, 1, 0);
    do_reset();  // CE held inactive here
    total++;
    if ({o_PAGE_OK, o_PAGE_INVAL, o_RETRY_REQ, o_ERR_FATAL, o_BUSY, o_RETRY_CNT} !== 8'h00) begin
      bad++; $display("FAIL mrst_mid got=%b want=00000000",
                      {o_PAGE_OK, o_PAGE_INVAL, o_RETRY_REQ, o_ERR_FATAL, o_BUSY, o_RETRY_CNT});
    end
    // Finishing the old page must not be judged: the sequencer is in IDLE.
    step(0, 1, 1'b0, 1, 0, 0);
    idle(3);
    total++;
    if (o_BUSY !== 1'b0) begin
      bad++; $display("FAIL mrst_discard got busy=%b want=0", o_BUSY);
    end
  endtask

  initial begin
    test_reset();
    test_ok();
    test_inval();
    test_short();
    test_ce_hold();
    test_abort();
    test_back_to_back();
    test_mrst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
